// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - MIPS control-flow encodings shared by decode-side redirect logic
//
// Purpose: opcode/funct constants, the NOP word and a small control-flow
// classifier used by id_redirect_unit.
// Ports: none (package).
package mips_ctrl_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_J     = 6'h02;
  localparam logic [5:0]  OP_JAL   = 6'h03;
  localparam logic [5:0]  OP_BEQ   = 6'h04;
  localparam logic [5:0]  OP_BNE   = 6'h05;
  localparam logic [5:0]  FN_JR    = 6'h08;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [2:0] {
    CF_NONE,
    CF_BEQ,
    CF_BNE,
    CF_JUMP,
    CF_JR
  } ctrl_kind_e;

  // Unknown opcodes and every R-type other than jr fall through to CF_NONE.
  function automatic ctrl_kind_e decode_ctrl(input logic [5:0] opcode,
                                             input logic [5:0] funct);
    ctrl_kind_e kind;
    kind = CF_NONE;
    case (opcode)
      OP_BEQ:   kind = CF_BEQ;
      OP_BNE:   kind = CF_BNE;
      OP_J,
      OP_JAL:   kind = CF_JUMP;
      OP_RTYPE: kind = (funct == FN_JR) ? CF_JR : CF_NONE;
      default:  kind = CF_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// rtl/branch_target_calc.sv - combinational candidate-target generator for decode redirects
//
// Purpose: produce the three possible redirect addresses for the instruction in D.
// Ports:
//   pc            in  32  PC of the instruction in D
//   instr_low     in  26  instruction bits [25:0] (imm16 / index26)
//   rs_data       in  32  forwarded rs value
//   branch_target out 32  pc + 4 + (sign_ext(imm16) << 2)
//   jump_target   out 32  {(pc+4)[31:28], index26, 2'b00}
//   jr_target     out 32  rs_data with the low two bits cleared
module branch_target_calc (
  input  logic [31:0] pc,
  input  logic [25:0] instr_low,
  input  logic [31:0] rs_data,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic [31:0] jr_target
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_offset;

  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{instr_low[15]}}, instr_low[15:0], 2'b00};

  assign branch_target = pc_plus4 + branch_offset;
  assign jump_target   = {pc_plus4[31:28], instr_low, 2'b00};
  assign jr_target     = rs_data & 32'hFFFF_FFFC;

endmodule

// File: rtl/id_redirect_unit.sv
// rtl/id_redirect_unit.sv - IF/ID register with decode-stage branch/jump resolution
//
// Purpose: registers the fetched instruction/PC, resolves beq/bne/j/jal/jr in
// decode, drives the redirect back to fetch and kills the one wrong-path slot.
// Optional feature macro: ID_REDIRECT_STATS_EN (adds redirect/flush counters).
// Ports:
//   clk, rst          in   clock (rising edge), async active-high reset
//   instruction_F     in   32  instruction from fetch
//   PC_F              in   32  PC of instruction_F
//   stall_D           in   1   hold IF/ID, suppress redirect
//   rs_data_D         in   32  forwarded rs value
//   rt_data_D         in   32  forwarded rt value
//   PC_src            out  1   fetch takes PC_target
//   PC_target         out  32  redirect address (0 when PC_src=0)
//   instruction_D     out  32  registered instruction (NOP when killed)
//   PC_D              out  32  registered PC
//   valid_D           out  1   D slot holds a live instruction
//   link_we_D         out  1   jal in D, valid, not stalled
//   link_value_D      out  32  PC_D + 4
//   redirect_count    out  32  (stats build) saturating count of redirect cycles
//   flush_count       out  32  (stats build) saturating count of flush loads
module id_redirect_unit
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_F,
  input  logic [31:0] PC_F,
  input  logic        stall_D,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] rt_data_D,
  output logic        PC_src,
  output logic [31:0] PC_target,
  output logic [31:0] instruction_D,
  output logic [31:0] PC_D,
  output logic        valid_D,
  output logic        link_we_D,
  output logic [31:0] link_value_D
`ifdef ID_REDIRECT_STATS_EN
  ,
  output logic [31:0] redirect_count,
  output logic [31:0] flush_count
`endif
);

  ctrl_kind_e  kind;
  logic        taken;
  logic        flush_load;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] selected_target;

  branch_target_calc u_target (
    .pc            (PC_D),
    .instr_low     (instruction_D[25:0]),
    .rs_data       (rs_data_D),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .jr_target     (jr_target)
  );

  always_comb begin
    kind            = decode_ctrl(instruction_D[31:26], instruction_D[5:0]);
    taken           = 1'b0;
    selected_target = 32'h0;
    case (kind)
      CF_BEQ: begin
        taken           = (rs_data_D == rt_data_D);
        selected_target = branch_target;
      end
      CF_BNE: begin
        taken           = (rs_data_D != rt_data_D);
        selected_target = branch_target;
      end
      CF_JUMP: begin
        taken           = 1'b1;
        selected_target = jump_target;
      end
      CF_JR: begin
        taken           = 1'b1;
        selected_target = jr_target;
      end
      default: begin
        taken           = 1'b0;
        selected_target = 32'h0;
      end
    endcase
  end

  // A killed slot has valid_D=0, so back-to-back redirects are impossible.
  // Stall masks the redirect entirely; it is re-evaluated once stall drops.
  assign PC_src       = valid_D & taken & ~stall_D;
  assign PC_target    = PC_src ? selected_target : 32'h0;
  assign link_we_D    = valid_D & ~stall_D & (instruction_D[31:26] == OP_JAL);
  assign link_value_D = PC_D + 32'd4;

  // PC_src already excludes stall, so every redirect edge is a flush edge.
  assign flush_load   = PC_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_D <= NOP;
      PC_D          <= RESET_PC;
      valid_D       <= 1'b0;
    end else if (!stall_D) begin
      if (flush_load) begin
        instruction_D <= NOP;
        PC_D          <= PC_F;
        valid_D       <= 1'b0;
      end else begin
        instruction_D <= instruction_F;
        PC_D          <= PC_F;
        valid_D       <= 1'b1;
      end
    end
  end

`ifdef ID_REDIRECT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_count <= 32'h0;
      flush_count    <= 32'h0;
    end else begin
      if (PC_src && (redirect_count != 32'hFFFF_FFFF)) begin
        redirect_count <= redirect_count + 32'd1;
      end
      if (flush_load && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_redirect_unit.sv
// tb/tb_id_redirect_unit.sv - randomized self-checking bench for id_redirect_unit
module tb_id_redirect_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction_F;
  logic [31:0] PC_F;
  logic        stall_D;
  logic [31:0] rs_data_D;
  logic [31:0] rt_data_D;
  logic        PC_src;
  logic [31:0] PC_target;
  logic [31:0] instruction_D;
  logic [31:0] PC_D;
  logic        valid_D;
  logic        link_we_D;
  logic [31:0] link_value_D;
`ifdef ID_REDIRECT_STATS_EN
  logic [31:0] redirect_count;
  logic [31:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  id_redirect_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction_F (instruction_F),
    .PC_F          (PC_F),
    .stall_D       (stall_D),
    .rs_data_D     (rs_data_D),
    .rt_data_D     (rt_data_D),
    .PC_src        (PC_src),
    .PC_target     (PC_target),
    .instruction_D (instruction_D),
    .PC_D          (PC_D),
    .valid_D       (valid_D),
    .link_we_D     (link_we_D),
    .link_value_D  (link_value_D)
`ifdef ID_REDIRECT_STATS_EN
    ,
    .redirect_count(redirect_count),
    .flush_count   (flush_count)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pc    = 32'h0;
  bit          m_valid = 0;
  logic [31:0] m_rc    = 32'h0;
  logic [31:0] m_fc    = 32'h0;

  function automatic bit m_taken(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    case (int'(ins[31:26]))
      4:       return rs == rt;
      5:       return rs != rt;
      2, 3:    return 1'b1;
      0:       return int'(ins[5:0]) == 8;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs);
    logic signed [15:0] imm;
    int off;
    int op;
    op  = int'(ins[31:26]);
    imm = ins[15:0];
    off = imm * 4;
    if (op == 4 || op == 5) return pc + 32'd4 + 32'(off);
    if (op == 2 || op == 3) return ((pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    return rs & 32'hFFFF_FFFC;
  endfunction

  wire        e_src = m_valid && m_taken(m_instr, rs_data_D, rt_data_D) && !stall_D;
  wire [31:0] e_tgt = e_src ? m_target(m_instr, m_pc, rs_data_D) : 32'h0;
  wire        e_lwe = m_valid && !stall_D && (m_instr[31:26] == 6'd3);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_instr <= 32'h0;
      m_pc    <= 32'h0;
      m_valid <= 0;
      m_rc    <= 32'h0;
      m_fc    <= 32'h0;
    end else begin
      if (!stall_D) begin
        m_instr <= e_src ? 32'h0 : instruction_F;
        m_pc    <= PC_F;
        m_valid <= !e_src;
      end
      if (e_src && m_rc != 32'hFFFF_FFFF) m_rc <= m_rc + 1;
      if (e_src && m_fc != 32'hFFFF_FFFF) m_fc <= m_fc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("PC_src",        {31'b0, PC_src},   {31'b0, e_src});
      chk("PC_target",     PC_target,         e_tgt);
      chk("instruction_D", instruction_D,     m_instr);
      chk("PC_D",          PC_D,              m_pc);
      chk("valid_D",       {31'b0, valid_D},  {31'b0, m_valid});
      chk("link_we_D",     {31'b0, link_we_D},{31'b0, e_lwe});
      chk("link_value_D",  link_value_D,      m_pc + 32'd4);
`ifdef ID_REDIRECT_STATS_EN
      chk("redirect_count", redirect_count, m_rc);
      chk("flush_count",    flush_count,    m_fc);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] i, input logic [31:0] p);
    instruction_F = i;
    PC_F          = p;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'h04, r[25:0]};
      1: return {6'h05, r[25:0]};
      2: return {6'h02, r[25:0]};
      3: return {6'h03, r[25:0]};
      4: return {6'h00, r[25:6], 6'h08};
      5: return {6'h00, r[25:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    rst = 1; stall_D = 0; rs_data_D = 0; rt_data_D = 0;
    fetch(32'h0, 32'h0);
    #3 chk_en = 1;

    // reset values
    mid();
    chk("rst_PC_src",    {31'b0, PC_src},  32'h0);
    chk("rst_PC_target", PC_target,        32'h0);
    chk("rst_instr",     instruction_D,    32'h0);
    chk("rst_PC_D",      PC_D,             32'h0);
    chk("rst_valid",     {31'b0, valid_D}, 32'h0);
    #2 rst = 0;

    // beq taken at 0x40
    fetch(32'h1000_0003, 32'h40); rs_data_D = 5; rt_data_D = 5;
    tick(); fetch(32'h0, 32'h44);
    mid();
    chk("beq_src",    {31'b0, PC_src}, 32'h1);
    chk("beq_target", PC_target,       32'h50);
    tick(); fetch(32'h1400_0003, 32'h40);
    mid();
    chk("beq_kill_valid", {31'b0, valid_D}, 32'h0);
    chk("beq_kill_instr", instruction_D,    32'h0);
`ifdef ID_REDIRECT_STATS_EN
    chk("beq_flush_cnt",  flush_count,      32'h1);
`endif

    // bne not taken
    tick(); rs_data_D = 7; rt_data_D = 7; fetch(32'h2402_0001, 32'h44);
    mid();
    chk("bne_src",    {31'b0, PC_src}, 32'h0);
    chk("bne_target", PC_target,       32'h0);
    tick(); fetch(32'h0C00_0100, 32'h1000_0010);
    mid();
    chk("bne_next_instr", instruction_D,    32'h2402_0001);
    chk("bne_next_pc",    PC_D,             32'h44);
    chk("bne_next_valid", {31'b0, valid_D}, 32'h1);

    // jal
    tick(); fetch(32'h0, 32'h1000_0014);
    mid();
    chk("jal_src",    {31'b0, PC_src},    32'h1);
    chk("jal_target", PC_target,          32'h1000_0400);
    chk("jal_lwe",    {31'b0, link_we_D}, 32'h1);
    chk("jal_lval",   link_value_D,       32'h1000_0014);
    tick(); fetch(32'h03E0_0008, 32'h1000_0400);
    mid();

    // jr
    tick(); rs_data_D = 32'h2003; fetch(32'h0, 32'h1000_0404);
    mid();
    chk("jr_src",    {31'b0, PC_src}, 32'h1);
    chk("jr_target", PC_target,       32'h2000);

    // beq taken under a 3-cycle stall
    tick(); fetch(32'h1000_0003, 32'h80); rs_data_D = 1; rt_data_D = 1;
    mid();
    tick(); stall_D = 1; fetch(32'h2402_0001, 32'h84);
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("stall_src",   {31'b0, PC_src},  32'h0);
      chk("stall_pc",    PC_D,             32'h80);
      chk("stall_instr", instruction_D,    32'h1000_0003);
      chk("stall_valid", {31'b0, valid_D}, 32'h1);
      tick(); fetch(32'h2402_0010 + k, 32'h84);
      if (k == 2) stall_D = 0;
    end
    mid();
    chk("unstall_src",    {31'b0, PC_src}, 32'h1);
    chk("unstall_target", PC_target,       32'h90);
    tick(); fetch(32'h2402_0005, 32'h90);
    mid();
    chk("unstall_kill", {31'b0, valid_D}, 32'h0);
    tick(); fetch(32'h2402_0006, 32'h94);
    mid();
    chk("unstall_live", {31'b0, valid_D}, 32'h1);
    chk("unstall_pc",   PC_D,             32'h90);
`ifdef ID_REDIRECT_STATS_EN
    chk("flush_total",  flush_count,      32'h4);
    chk("redir_total",  redirect_count,   32'h4);
`endif

    // reset in the redirect cycle
    tick(); fetch(32'h1000_0003, 32'h100); rs_data_D = 9; rt_data_D = 9;
    tick(); fetch(32'h0, 32'h104);
    mid();
    chk("pre_rst_src", {31'b0, PC_src}, 32'h1);
    #2 rst = 1;
    #1;
    chk("mid_rst_src",    {31'b0, PC_src},    32'h0);
    chk("mid_rst_target", PC_target,          32'h0);
    chk("mid_rst_instr",  instruction_D,      32'h0);
    chk("mid_rst_valid",  {31'b0, valid_D},   32'h0);
    chk("mid_rst_lwe",    {31'b0, link_we_D}, 32'h0);
    mid();
    #2 rst = 0; fetch(32'h2402_0007, 32'h200);
    tick();
    mid();
    chk("post_rst_valid", {31'b0, valid_D}, 32'h1);
    chk("post_rst_pc",    PC_D,             32'h200);
    chk("post_rst_instr", instruction_D,    32'h2402_0007);

    // randomized phase; compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (rst) rst = 0;
      else if ($urandom_range(0, 199) == 0) rst = 1;
      fetch(rand_instr(), $urandom & 32'hFFFF_FFFC);
      stall_D   = ($urandom_range(0, 3) == 0);
      rs_data_D = $urandom;
      rt_data_D = ($urandom_range(0, 1) == 0) ? rs_data_D : $urandom;
    end

    mid();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
